// File: rtl/phys_ram_pkg.sv
// Shared definitions for the physical RAM arbiter: FSM state encoding,
// default bus widths and the channel-count limit.
package phys_ram_pkg;

   localparam int DEFAULT_ADDR_W = 32;
   localparam int DEFAULT_DATA_W = 32;
   localparam int MAX_NUM_CH     = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_ACK     = 2'd3
   } arb_state_e;

   // Index width that stays at least one bit for a single channel.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/phys_ram_arbiter_if.sv
// Requester-side and RAM-side bus of the physical RAM arbiter.
// Handshake: a channel holds chReadReq/chWriteReq high until it sees its one-cycle chAck pulse.
interface phys_ram_arbiter_if
   import phys_ram_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int DATA_W = DEFAULT_DATA_W
);

   logic [NUM_CH-1:0]        chReadReq;
   logic [NUM_CH-1:0]        chWriteReq;
   logic [NUM_CH*ADDR_W-1:0] chAddress;
   logic [NUM_CH*DATA_W-1:0] chWriteData;
   logic [NUM_CH-1:0]        chAck;
   logic [DATA_W-1:0]        chReadData;
   logic [ADDR_W-1:0]        ramAddress;
   logic                     ramWriteEnable;
   logic [DATA_W-1:0]        ramWrite;
   logic [DATA_W-1:0]        ramRead;

   modport slave (
      input  chReadReq, chWriteReq, chAddress, chWriteData, ramRead,
      output chAck, chReadData, ramAddress, ramWriteEnable, ramWrite
   );

   modport master (
      output chReadReq, chWriteReq, chAddress, chWriteData, ramRead,
      input  chAck, chReadData, ramAddress, ramWriteEnable, ramWrite
   );

endinterface

// File: rtl/phys_ram_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first requesting channel after last_grant
// (wrapping) wins; grant_valid is low when nothing is requested.
module rr_arbiter
   import phys_ram_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int IDX_W  = idx_width(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [IDX_W-1:0]  last_grant,
   output logic [IDX_W-1:0]  grant_idx,
   output logic              grant_valid
);

   // Walk offsets from farthest to nearest so the nearest requester overwrites.
   always_comb begin
      grant_idx   = '0;
      grant_valid = 1'b0;
      for (int off = NUM_CH; off >= 1; off--) begin
         for (int j = 0; j < NUM_CH; j++) begin
            if (req[j] && (j == (int'(last_grant) + off) % NUM_CH)) begin
               grant_idx   = IDX_W'(j);
               grant_valid = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/phys_ram_arbiter.sv
// Multi-channel arbiter in front of a single-port RAM, one access in flight at a time.
// Optional per-channel completion counters are enabled by PHYS_RAM_ARB_STATS_EN.
module phys_ram_arbiter
   import phys_ram_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic                 clk,
   input  logic                 reset,
   phys_ram_arbiter_if.slave    bus,
   output arb_state_e           dbg_state
`ifdef PHYS_RAM_ARB_STATS_EN
   ,
   output logic [NUM_CH*16-1:0] grantCount
`endif
);

   localparam int IDX_W = idx_width(NUM_CH);

   arb_state_e        state_q, state_d;
   logic [IDX_W-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0]  last_grant_q, last_grant_d;
   logic              is_write_q, is_write_d;
   logic [NUM_CH-1:0] ch_ack_q, ch_ack_d;
   logic [DATA_W-1:0] ch_read_data_q, ch_read_data_d;
   logic [ADDR_W-1:0] ram_address_q, ram_address_d;
   logic [DATA_W-1:0] ram_write_q, ram_write_d;
   logic              ram_we_q, ram_we_d;

   logic [NUM_CH-1:0] req_any;
   logic [IDX_W-1:0]  pick_idx;
   logic              pick_valid;

   assign req_any = bus.chReadReq | bus.chWriteReq;

   rr_arbiter #(
      .NUM_CH (NUM_CH),
      .IDX_W  (IDX_W)
   ) u_rr (
      .req         (req_any),
      .last_grant  (last_grant_q),
      .grant_idx   (pick_idx),
      .grant_valid (pick_valid)
   );

   always_comb begin
      state_d        = state_q;
      grant_d        = grant_q;
      last_grant_d   = last_grant_q;
      is_write_d     = is_write_q;
      ch_ack_d       = '0;
      ch_read_data_d = ch_read_data_q;
      ram_address_d  = ram_address_q;
      ram_write_d    = ram_write_q;
      ram_we_d       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               grant_d = pick_idx;
               state_d = ST_ACCESS;
               // Write wins when a channel raises both requests.
               for (int j = 0; j < NUM_CH; j++) begin
                  if (pick_idx == IDX_W'(j)) begin
                     is_write_d    = bus.chWriteReq[j];
                     ram_we_d      = bus.chWriteReq[j];
                     ram_address_d = bus.chAddress[j*ADDR_W +: ADDR_W];
                     ram_write_d   = bus.chWriteData[j*DATA_W +: DATA_W];
                  end
               end
            end
         end
         ST_ACCESS: begin
            state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (!is_write_q) begin
               ch_read_data_d = bus.ramRead;
            end
            for (int j = 0; j < NUM_CH; j++) begin
               if (grant_q == IDX_W'(j)) begin
                  ch_ack_d[j] = 1'b1;
               end
            end
            state_d = ST_ACK;
         end
         ST_ACK: begin
            last_grant_d = grant_q;
            state_d      = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         grant_q        <= '0;
         last_grant_q   <= IDX_W'(NUM_CH - 1);
         is_write_q     <= 1'b0;
         ch_ack_q       <= '0;
         ch_read_data_q <= '0;
         ram_address_q  <= '0;
         ram_write_q    <= '0;
         ram_we_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         grant_q        <= grant_d;
         last_grant_q   <= last_grant_d;
         is_write_q     <= is_write_d;
         ch_ack_q       <= ch_ack_d;
         ch_read_data_q <= ch_read_data_d;
         ram_address_q  <= ram_address_d;
         ram_write_q    <= ram_write_d;
         ram_we_q       <= ram_we_d;
      end
   end

   assign bus.chAck          = ch_ack_q;
   assign bus.chReadData     = ch_read_data_q;
   assign bus.ramAddress     = ram_address_q;
   assign bus.ramWrite       = ram_write_q;
   assign bus.ramWriteEnable = ram_we_q;
   assign dbg_state          = state_q;

`ifdef PHYS_RAM_ARB_STATS_EN
   logic [15:0] grant_count_q [NUM_CH];
   logic [15:0] grant_count_d [NUM_CH];

   // Counts on the edge that raises chAck and saturates at all-ones.
   always_comb begin
      for (int j = 0; j < NUM_CH; j++) begin
         grant_count_d[j] = grant_count_q[j];
         if (state_q == ST_CAPTURE && grant_q == IDX_W'(j) && grant_count_q[j] != 16'hFFFF) begin
            grant_count_d[j] = grant_count_q[j] + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int j = 0; j < NUM_CH; j++) begin
            grant_count_q[j] <= '0;
         end
      end else begin
         for (int j = 0; j < NUM_CH; j++) begin
            grant_count_q[j] <= grant_count_d[j];
         end
      end
   end

   always_comb begin
      for (int j = 0; j < NUM_CH; j++) begin
         grantCount[j*16 +: 16] = grant_count_q[j];
      end
   end
`endif

endmodule

// File: tb/tb_phys_ram_arbiter.sv
// Directed bench for phys_ram_arbiter: a 2-channel and a 4-channel instance,
// each in front of a small registered-read RAM model.
module tb_phys_ram_arbiter;
  import phys_ram_pkg::*;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  phys_ram_arbiter_if #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32)) bus2 ();
  phys_ram_arbiter_if #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32)) bus4 ();
  arb_state_e dbg2;
  arb_state_e dbg4;
`ifdef PHYS_RAM_ARB_STATS_EN
  logic [31:0] gc2;
  logic [63:0] gc4;
`endif

  phys_ram_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus2), .dbg_state(dbg2)
`ifdef PHYS_RAM_ARB_STATS_EN
    , .grantCount(gc2)
`endif
  );

  phys_ram_arbiter #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4), .dbg_state(dbg4)
`ifdef PHYS_RAM_ARB_STATS_EN
    , .grantCount(gc4)
`endif
  );

  // clock / RAM models
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem2 [256];
  logic [31:0] mem4 [256];

  always @(posedge clk) begin
    if (bus2.ramWriteEnable) mem2[bus2.ramAddress[7:0]] <= bus2.ramWrite;
    bus2.ramRead <= mem2[bus2.ramAddress[7:0]];
    if (bus4.ramWriteEnable) mem4[bus4.ramAddress[7:0]] <= bus4.ramWrite;
    bus4.ramRead <= mem4[bus4.ramAddress[7:0]];
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_access(input int ch, input logic wr, input logic rd,
                            input logic [31:0] addr, input logic [31:0] data,
                            output int lat, output logic [1:0] ackv,
                            output logic [31:0] rdata, output logic we0, output logic we1);
    bus2.chWriteReq[ch] = wr;
    bus2.chReadReq[ch] = rd;
    bus2.chAddress[ch*32 +: 32] = addr;
    bus2.chWriteData[ch*32 +: 32] = data;
    lat = -1;
    ackv = 2'b00;
    rdata = 32'h0;
    we0 = 1'b0;
    we1 = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 1) we0 = bus2.ramWriteEnable;
      if (i == 2) we1 = bus2.ramWriteEnable;
      if (bus2.chAck != 2'b00) begin
        lat = i;
        ackv = bus2.chAck;
        rdata = bus2.chReadData;
        break;
      end
    end
    bus2.chWriteReq[ch] = 1'b0;
    bus2.chReadReq[ch] = 1'b0;
    step();
  endtask

  // tests
  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    n_total++; if (dbg2 !== ST_IDLE) $display("FAIL rst_state: got %0d expected %0d", dbg2, ST_IDLE); else n_pass++;
    n_total++; if (bus2.chAck !== 2'b00) $display("FAIL rst_ack: got %b expected 00", bus2.chAck); else n_pass++;
    n_total++; if (bus2.chReadData !== 32'h0) $display("FAIL rst_rdata: got %h expected 0", bus2.chReadData); else n_pass++;
    n_total++; if (bus2.ramAddress !== 32'h0) $display("FAIL rst_addr: got %h expected 0", bus2.ramAddress); else n_pass++;
    n_total++; if (bus2.ramWrite !== 32'h0) $display("FAIL rst_wdata: got %h expected 0", bus2.ramWrite); else n_pass++;
    n_total++; if (bus2.ramWriteEnable !== 1'b0) $display("FAIL rst_we: got %b expected 0", bus2.ramWriteEnable); else n_pass++;
    n_total++; if (bus4.chAck !== 4'b0000) $display("FAIL rst_ack4: got %b expected 0000", bus4.chAck); else n_pass++;
    reset = 1'b1;
    step();
    n_total++; if (bus2.ramWriteEnable !== 1'b0) $display("FAIL idle_we: got %b expected 0", bus2.ramWriteEnable); else n_pass++;
  endtask

  task automatic test_write_read();
    int lat; logic [1:0] ackv; logic [31:0] rd; logic we0, we1;
    drv_access(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, lat, ackv, rd, we0, we1);
    n_total++; if (lat !== 3) $display("FAIL wr_latency: got %0d expected 3", lat); else n_pass++;
    n_total++; if (ackv !== 2'b01) $display("FAIL wr_ack: got %b expected 01", ackv); else n_pass++;
    n_total++; if (we0 !== 1'b1) $display("FAIL wr_we_e0: got %b expected 1", we0); else n_pass++;
    n_total++; if (we1 !== 1'b0) $display("FAIL wr_we_e1: got %b expected 0", we1); else n_pass++;
    drv_access(0, 1'b0, 1'b1, 32'h10, 32'h0, lat, ackv, rd, we0, we1);
    n_total++; if (lat !== 3) $display("FAIL rd_latency: got %0d expected 3", lat); else n_pass++;
    n_total++; if (ackv !== 2'b01) $display("FAIL rd_ack: got %b expected 01", ackv); else n_pass++;
    n_total++; if (rd !== 32'hDEADBEEF) $display("FAIL rd_data: got %h expected deadbeef", rd); else n_pass++;
    n_total++; if (we0 !== 1'b0) $display("FAIL rd_we_e0: got %b expected 0", we0); else n_pass++;
    n_total++; if (bus2.chAck !== 2'b00) $display("FAIL rd_ack_drop: got %b expected 00", bus2.chAck); else n_pass++;
  endtask

  task automatic test_read_write_both();
    int lat; logic [1:0] ackv; logic [31:0] rd; logic we0, we1;
    drv_access(1, 1'b1, 1'b1, 32'h20, 32'h5, lat, ackv, rd, we0, we1);
    n_total++; if (ackv !== 2'b10) $display("FAIL both_ack: got %b expected 10", ackv); else n_pass++;
    n_total++; if (we0 !== 1'b1) $display("FAIL both_is_write: got %b expected 1", we0); else n_pass++;
    n_total++; if (rd !== 32'hDEADBEEF) $display("FAIL both_rdata_hold: got %h expected deadbeef", rd); else n_pass++;
    drv_access(1, 1'b0, 1'b1, 32'h20, 32'h0, lat, ackv, rd, we0, we1);
    n_total++; if (lat !== 3) $display("FAIL both_rb_latency: got %0d expected 3", lat); else n_pass++;
    n_total++; if (rd !== 32'h5) $display("FAIL both_readback: got %h expected 5", rd); else n_pass++;
  endtask

  task automatic test_capture_drop();
    int lat; logic [1:0] ackv; logic [31:0] rd; logic we0, we1;
    bus2.chWriteReq[0] = 1'b1;
    bus2.chAddress[31:0] = 32'h50;
    bus2.chWriteData[31:0] = 32'h1234;
    step();
    bus2.chAddress[31:0] = 32'h99;
    bus2.chWriteData[31:0] = 32'hBAD;
    bus2.chWriteReq[0] = 1'b0;
    n_total++; if (bus2.ramAddress !== 32'h50) $display("FAIL cap_addr: got %h expected 50", bus2.ramAddress); else n_pass++;
    n_total++; if (bus2.ramWrite !== 32'h1234) $display("FAIL cap_wdata: got %h expected 1234", bus2.ramWrite); else n_pass++;
    lat = -1;
    ackv = 2'b00;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (bus2.chAck != 2'b00) begin
        lat = i;
        ackv = bus2.chAck;
        break;
      end
    end
    n_total++; if (lat !== 2) $display("FAIL drop_ack_cycle: got %0d expected 2", lat); else n_pass++;
    n_total++; if (ackv !== 2'b01) $display("FAIL drop_ack: got %b expected 01", ackv); else n_pass++;
    step();
    drv_access(0, 1'b0, 1'b1, 32'h50, 32'h0, lat, ackv, rd, we0, we1);
    n_total++; if (rd !== 32'h1234) $display("FAIL cap_readback: got %h expected 1234", rd); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_ack [4];
    logic [31:0] exp_dat [4];
    logic [1:0]  got_ack [4];
    logic [31:0] got_dat [4];
    int          got_stp [4];
    int          n;
    exp_ack = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_dat = '{32'hDEADBEEF, 32'h5, 32'hDEADBEEF, 32'h5};
    n = 0;
    reset = 1'b0;
    step();
    bus2.chAddress = {32'h20, 32'h10};
    bus2.chReadReq = 2'b11;
    reset = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (bus2.chAck != 2'b00) begin
        if (n < 4) begin
          got_ack[n] = bus2.chAck;
          got_dat[n] = bus2.chReadData;
          got_stp[n] = i;
        end
        n++;
      end
    end
    bus2.chReadReq = 2'b00;
    n_total++; if (n !== 4) $display("FAIL rr_count: got %0d expected 4", n); else n_pass++;
    for (int k = 0; k < 4 && k < n; k++) begin
      n_total++; if (got_ack[k] !== exp_ack[k]) $display("FAIL rr_order[%0d]: got %b expected %b", k, got_ack[k], exp_ack[k]); else n_pass++;
      n_total++; if (got_stp[k] !== 3 + 4*k) $display("FAIL rr_cycle[%0d]: got %0d expected %0d", k, got_stp[k], 3 + 4*k); else n_pass++;
      n_total++; if (got_dat[k] !== exp_dat[k]) $display("FAIL rr_data[%0d]: got %h expected %h", k, got_dat[k], exp_dat[k]); else n_pass++;
    end
    step();
  endtask

  task automatic test_reset_mid_access();
    int lat; logic [1:0] ackv; logic [31:0] rd; logic we0, we1;
    logic stray_ack;
    drv_access(0, 1'b0, 1'b1, 32'h10, 32'h0, lat, ackv, rd, we0, we1);
    bus2.chWriteReq[1] = 1'b1;
    bus2.chAddress[63:32] = 32'h60;
    bus2.chWriteData[63:32] = 32'h77;
    step();
    n_total++; if (bus2.ramWriteEnable !== 1'b1) $display("FAIL mid_we_before: got %b expected 1", bus2.ramWriteEnable); else n_pass++;
    n_total++; if (dbg2 !== ST_ACCESS) $display("FAIL mid_state_before: got %0d expected %0d", dbg2, ST_ACCESS); else n_pass++;
    #2;
    reset = 1'b0;
    #1;
    n_total++; if (bus2.ramWriteEnable !== 1'b0) $display("FAIL mid_we_async: got %b expected 0", bus2.ramWriteEnable); else n_pass++;
    n_total++; if (dbg2 !== ST_IDLE) $display("FAIL mid_state_async: got %0d expected %0d", dbg2, ST_IDLE); else n_pass++;
    bus2.chWriteReq[1] = 1'b0;
    stray_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (bus2.chAck != 2'b00) stray_ack = 1'b1;
    end
    bus2.chAddress = {32'h20, 32'h10};
    bus2.chReadReq = 2'b11;
    reset = 1'b1;
    lat = -1;
    ackv = 2'b00;
    rd = 32'h0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (bus2.chAck != 2'b00) begin
        lat = i;
        ackv = bus2.chAck;
        rd = bus2.chReadData;
        break;
      end
    end
    bus2.chReadReq = 2'b00;
    n_total++; if (stray_ack !== 1'b0) $display("FAIL mid_no_ack: got %b expected 0", stray_ack); else n_pass++;
    n_total++; if (lat !== 3) $display("FAIL mid_next_latency: got %0d expected 3", lat); else n_pass++;
    n_total++; if (ackv !== 2'b01) $display("FAIL mid_next_grant: got %b expected 01", ackv); else n_pass++;
    n_total++; if (rd !== 32'hDEADBEEF) $display("FAIL mid_next_data: got %h expected deadbeef", rd); else n_pass++;
    step();
  endtask

  task automatic test_wrap();
    logic [3:0] exp_ack [3];
    logic [3:0] got_ack [3];
    int         got_stp [3];
    int         n;
    exp_ack = '{4'b0010, 4'b1000, 4'b0010};
    n = 0;
    reset = 1'b0;
    step();
    bus4.chReadReq = 4'b1010;
    reset = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (bus4.chAck != 4'b0000) begin
        if (n < 3) begin
          got_ack[n] = bus4.chAck;
          got_stp[n] = i;
        end
        n++;
      end
    end
    bus4.chReadReq = 4'b0000;
    n_total++; if (n !== 3) $display("FAIL wrap_count: got %0d expected 3", n); else n_pass++;
    for (int k = 0; k < 3 && k < n; k++) begin
      n_total++; if (got_ack[k] !== exp_ack[k]) $display("FAIL wrap_order[%0d]: got %b expected %b", k, got_ack[k], exp_ack[k]); else n_pass++;
      n_total++; if (got_stp[k] !== 3 + 4*k) $display("FAIL wrap_cycle[%0d]: got %0d expected %0d", k, got_stp[k], 3 + 4*k); else n_pass++;
    end
    step();
  endtask

`ifdef PHYS_RAM_ARB_STATS_EN
  task automatic test_stats();
    int lat; logic [1:0] ackv; logic [31:0] rd; logic we0, we1;
    reset = 1'b0;
    step();
    n_total++; if (gc2 !== 32'h0) $display("FAIL stats_reset: got %h expected 0", gc2); else n_pass++;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) drv_access(0, 1'b0, 1'b1, 32'h10, 32'h0, lat, ackv, rd, we0, we1);
    for (int i = 0; i < 3; i++) drv_access(1, 1'b0, 1'b1, 32'h20, 32'h0, lat, ackv, rd, we0, we1);
    n_total++; if (gc2 !== {16'd3, 16'd5}) $display("FAIL stats_count: got %h expected 00030005", gc2); else n_pass++;
  endtask
`endif

  // main sequence and report
  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b0;
    bus2.chReadReq = '0;
    bus2.chWriteReq = '0;
    bus2.chAddress = '0;
    bus2.chWriteData = '0;
    bus4.chReadReq = '0;
    bus4.chWriteReq = '0;
    bus4.chAddress = '0;
    bus4.chWriteData = '0;
    test_reset();
    test_write_read();
    test_read_write_both();
    test_capture_drop();
    test_round_robin();
    test_reset_mid_access();
    test_wrap();
`ifdef PHYS_RAM_ARB_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/phys_ram_arbiter.md
PHYS_RAM_ARBITER -- requirements
Module: phys_ram_arbiter

Interface
REQ-001 Parameter NUM_CH, default 2: number of requester channels, range 1..8.
REQ-002 Parameter ADDR_W, default 32: word address width.
REQ-003 Parameter DATA_W, default 32: data word width.
REQ-004 clk  input  1: single clock; all state updates on rising edge.
REQ-005 reset  input  1: asynchronous, active-low reset.
REQ-006 chReadReq  input  NUM_CH: per-channel read request, level, held until chAck.
REQ-007 chWriteReq  input  NUM_CH: per-channel write request, level, held until chAck.
REQ-008 chAddress  input  NUM_CH*ADDR_W: per-channel address; channel i in slice [i*ADDR_W +: ADDR_W].
REQ-009 chWriteData  input  NUM_CH*DATA_W: per-channel write data, same slicing.
REQ-010 chAck  output  NUM_CH: one-cycle completion pulse, at most one bit high.
REQ-011 chReadData  output  DATA_W: read data, valid in the cycle chAck is high, shared by all channels.
REQ-012 ramAddress  output  ADDR_W: address to the physical RAM, registered.
REQ-013 ramWriteEnable  output  1: RAM write strobe, registered.
REQ-014 ramWrite  output  DATA_W: RAM write data, registered.
REQ-015 ramRead  input  DATA_W: RAM read data, valid one cycle after the address edge.

Function
REQ-016 FSM states: IDLE, ACCESS, CAPTURE, ACK; only one access is outstanding at a time.
REQ-017 IDLE: if any request is pending, grant the channel found by a round-robin search starting at lastGrant+1 mod NUM_CH; load ramAddress, ramWrite and ramWriteEnable (1 for a write, 0 for a read); go to ACCESS.
REQ-018 IDLE with no request: hold ramWriteEnable=0 and stay in IDLE.
REQ-019 ACCESS: the RAM samples the address and strobe; drop ramWriteEnable to 0; go to CAPTURE.
REQ-020 CAPTURE: on a read, register ramRead into chReadData; raise chAck[grant]; go to ACK.
REQ-021 ACK: lower chAck; update lastGrant to grant; return to IDLE.
REQ-022 Latency: requests are seen at edge E0 and chAck is high from E2 to E3 for reads and writes alike; back-to-back throughput is one access per 4 cycles.
REQ-023 If a channel raises read and write together, it is served as a write; chReadData holds its previous value.
REQ-024 The granted channel's address and data are captured at E0; later input changes do not affect the access in flight.
REQ-025 A request dropped before its chAck still completes, and the ack still pulses.
REQ-026 A channel whose request stays high after its ack is served again only in its round-robin turn.
REQ-027 lastGrant wraps from NUM_CH-1 to 0.
REQ-028 NUM_CH=1 degenerates to a single requester with identical timing.

Reset
REQ-029 While reset=0: state=IDLE, chAck=0, chReadData=0, ramAddress=0, ramWrite=0, ramWriteEnable=0, lastGrant=NUM_CH-1 so that channel 0 wins first.
REQ-030 Reset asserted mid-access aborts the access; ramWriteEnable falls to 0 asynchronously and no ack is issued after release.

Configuration
REQ-031 Macro PHYS_RAM_ARB_STATS_EN: when defined, add output grantCount (NUM_CH*16), a per-channel count of completed accesses that increments at the ack edge, saturates at 16'hFFFF and resets to 0.
REQ-032 When PHYS_RAM_ARB_STATS_EN is undefined: no grantCount port and no counter logic.

Structure
REQ-033 Package phys_ram_pkg holds the FSM state enum, the default ADDR_W/DATA_W constants and the maximum NUM_CH.
REQ-034 Sub-module rr_arbiter (combinational round-robin pick from the request vector and lastGrant, giving a grant index and valid) is instantiated once.

Verification
REQ-035 Reset, then ch0 writes 0xDEADBEEF to address 0x10, then reads 0x10 -> chAck[0] at E2 of each access; read returns 0xDEADBEEF.
REQ-036 ch0 and ch1 both read continuously at reset release -> grant order 0,1,0,1; acks 4 cycles apart.
REQ-037 ch1 raises read and write at address 0x20 with data 0x5 -> write performed; a following read of 0x20 returns 0x5.
REQ-038 NUM_CH=4 with only ch3 and ch1 requesting -> order 1,3,1 (wrap verified).
REQ-039 Reset pulled low in ACCESS during a write -> ramWriteEnable=0 immediately, no chAck, and the next access after release is granted to ch0.
REQ-040 With PHYS_RAM_ARB_STATS_EN defined, 5 ch0 accesses and 3 ch1 accesses -> grantCount = {16'd3, 16'd5}.
